mem_refill_arbiter: RTL and testbench

MEM_REFILL_ARBITER -- requirements
Module: mem_refill_arbiter

---
 rtl/mem_refill_arbiter.sv | 111 +++++++++++
 tb/tb_mem_refill_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_refill_arbiter.sv
// rtl/mem_refill_arbiter.sv - round-robin arbiter sharing one word-wide memory port between ICache refills and DCache refills/write-backs
module mem_refill_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                          CPU_CLK,
  input  logic                          CPU_RST_N,
  input  logic                          i_req,
  input  logic [ADDR_W-1:0]             i_addr,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [31:0]                   d_wdata,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic                          mem_ready,
  input  logic [31:0]                   mem_rdata,
  output logic                          i_rvalid,
  output logic                          d_rvalid,
  output logic [31:0]                   rdata,
  output logic [$clog2(LINE_WORDS)-1:0] word_idx,
  output logic                          i_done,
  output logic                          d_done,
  output logic                          owner
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} stateType;

  stateType          state, stateNext;
  logic [IDX_W-1:0]  cnt;
  logic [ADDR_W-1:0] base;
  logic              ownerQ, lastOwner, weQ;
  logic              grantD;

  // On a tie D wins unless D was the last one served (lastOwner: 0 = I, 1 = D).
  assign grantD = d_req && (!i_req || !lastOwner);

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) state <= IDLE;
    else            state <= stateNext;
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      cnt       <= '0;
      base      <= '0;
      ownerQ    <= 1'b0;
      lastOwner <= 1'b0;
      weQ       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_req || d_req) begin
          ownerQ <= grantD;
          weQ    <= grantD && d_we;
          base   <= (grantD ? d_addr : i_addr) & ALIGN_MASK;
          cnt    <= '0;
        end
        BURST: if (mem_ready) cnt <= cnt + IDX_W'(1);
        DONE:  lastOwner <= ownerQ;
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    rdata     = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    case (state)
      IDLE: if (i_req || d_req) stateNext = BURST;
      BURST: begin
        mem_req   = 1'b1;
        mem_we    = weQ;
        mem_addr  = base + ADDR_W'({cnt, 2'b00});
        mem_wdata = d_wdata;
        if (mem_ready) begin
          if (!weQ) begin
            i_rvalid = !ownerQ;
            d_rvalid = ownerQ;
            rdata    = mem_rdata;
          end
          if (cnt == LAST_IDX) stateNext = DONE;
        end
      end
      DONE: begin
        i_done    = !ownerQ;
        d_done    = ownerQ;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign word_idx = cnt;
  assign owner    = ownerQ;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// tb/tb_mem_refill_arbiter.sv - scoreboard bench for mem_refill_arbiter
module tb_mem_refill_arbiter;

  localparam int LW = 8;
  localparam int AW = 32;

  logic          CPU_CLK = 1'b0;
  logic          CPU_RST_N;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [31:0]   d_wdata;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata, rdata;
  logic          i_rvalid, d_rvalid, i_done, d_done, owner;
  logic [2:0]    word_idx;

  mem_refill_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST_N(CPU_RST_N),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .i_rvalid(i_rvalid), .d_rvalid(d_rvalid), .rdata(rdata), .word_idx(word_idx),
    .i_done(i_done), .d_done(d_done), .owner(owner)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  // Memory returns a tag of the address; the DCache supplies a tag of the word index.
  assign mem_rdata = mem_addr ^ 32'h5A5A_0000;
  assign d_wdata   = 32'hD0D0_0000 | {29'd0, word_idx};

  typedef struct packed {
    logic        own;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  idx;
  } beat_t;

  beat_t beatQ[$];
  logic  doneQ[$];
  int    tests = 0;
  int    fails = 0;
  logic  lastBeatPrev = 1'b0;
  int    readyMode = 0;
  int    readyPhase = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pushBurst(input logic own, input logic we, input logic [31:0] base, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.own  = own;
      b.we   = we;
      b.addr = base + 32'(4 * k);
      b.idx  = 3'(k);
      beatQ.push_back(b);
    end
    if (n == LW) doneQ.push_back(own);
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes a word or pulses done.
  always @(negedge CPU_CLK) begin
    beat_t b;
    logic  o;
    if (mem_req && mem_ready) begin
      if (beatQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got addr 0x%08h expected no beat", mem_addr);
      end else begin
        b = beatQ.pop_front();
        chk("beat_addr", mem_addr, b.addr);
        chk("beat_idx", 32'(word_idx), 32'(b.idx));
        chk("beat_we", 32'(mem_we), 32'(b.we));
        chk("beat_owner", 32'(owner), 32'(b.own));
        chk("i_rvalid", 32'(i_rvalid), 32'(!b.we && !b.own));
        chk("d_rvalid", 32'(d_rvalid), 32'(!b.we && b.own));
        if (b.we) chk("wdata", mem_wdata, 32'hD0D0_0000 | 32'(b.idx));
        else      chk("rdata", rdata, b.addr ^ 32'h5A5A_0000);
      end
    end else begin
      chk("rvalid_quiet", 32'({i_rvalid, d_rvalid}), 32'd0);
      if (mem_req && beatQ.size() > 0) begin
        chk("stall_addr", mem_addr, beatQ[0].addr);
        chk("stall_idx", 32'(word_idx), 32'(beatQ[0].idx));
      end
    end
    if (i_done || d_done) begin
      if (doneQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got i_done=%0d d_done=%0d expected none", i_done, d_done);
      end else begin
        o = doneQ.pop_front();
        chk("done_owner", 32'({i_done, d_done}), o ? 32'd1 : 32'd2);
        chk("done_after_last_beat", 32'(lastBeatPrev), 32'd1);
        chk("done_mem_req", 32'(mem_req), 32'd0);
      end
    end
    lastBeatPrev = mem_req && mem_ready && (word_idx == 3'd7);
  end

  task automatic runUntilDones(input int n, input int budget);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < budget) begin
      @(posedge CPU_CLK);
      #1;
      cyc++;
      if (readyMode == 1) begin
        mem_ready = (readyPhase % 4 == 0) || (readyPhase % 4 == 3);
        readyPhase++;
      end else begin
        mem_ready = 1'b1;
      end
      if (i_done) begin i_req = 1'b0; seen++; end
      if (d_done) begin d_req = 1'b0; seen++; end
    end
    chk("dones_within_budget", 32'(seen), 32'(n));
  endtask

  task automatic endPhase(input string name);
    @(negedge CPU_CLK);
    #1;
    chk({name, "_beats_drained"}, 32'(beatQ.size()), 32'd0);
    chk({name, "_dones_drained"}, 32'(doneQ.size()), 32'd0);
  endtask

  task automatic checkAllZero(input string name);
    chk({name, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({name, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({name, "_mem_addr"}, mem_addr, 32'd0);
    chk({name, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({name, "_word_idx"}, 32'(word_idx), 32'd0);
    chk({name, "_owner"}, 32'(owner), 32'd0);
    chk({name, "_rvalid"}, 32'({i_rvalid, d_rvalid}), 32'd0);
    chk({name, "_done"}, 32'({i_done, d_done}), 32'd0);
    chk({name, "_rdata"}, rdata, 32'd0);
  endtask

  initial begin
    int  cyc;
    logic hit;
    CPU_RST_N = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0;
    mem_ready = 1'b1;
    repeat (2) @(posedge CPU_CLK);
    #1;
    checkAllZero("reset");
    CPU_RST_N = 1'b1;

    // Simultaneous pair right after reset: D first, then I.
    pushBurst(1'b1, 1'b0, 32'h0000_0100, LW);
    pushBurst(1'b0, 1'b0, 32'h0000_0200, LW);
    i_addr = 32'h0000_0208; d_addr = 32'h0000_011C; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    runUntilDones(2, 100);
    endPhase("pair1");

    pushBurst(1'b0, 1'b0, 32'h0000_1220, LW);
    i_addr = 32'h0000_1234; i_req = 1'b1;
    runUntilDones(1, 50);
    endPhase("icache_refill");

    pushBurst(1'b1, 1'b1, 32'h0000_0040, LW);
    d_addr = 32'h0000_0040; d_we = 1'b1; d_req = 1'b1;
    runUntilDones(1, 50);
    endPhase("writeback");
    d_we = 1'b0;

    // D was served last, so this tie goes to I.
    pushBurst(1'b0, 1'b0, 32'h0000_0500, LW);
    pushBurst(1'b1, 1'b0, 32'h0000_0600, LW);
    i_addr = 32'h0000_0514; d_addr = 32'h0000_0600;
    i_req = 1'b1; d_req = 1'b1;
    runUntilDones(2, 100);
    endPhase("pair2");

    readyMode = 1; readyPhase = 0;
    pushBurst(1'b0, 1'b0, 32'h0000_2000, LW);
    i_addr = 32'h0000_2004; i_req = 1'b1;
    runUntilDones(1, 200);
    endPhase("stall");
    readyMode = 0;
    mem_ready = 1'b1;

    // Reset lands while word 3 is on the bus.
    pushBurst(1'b0, 1'b0, 32'h0000_3000, 3);
    i_addr = 32'h0000_3000; i_req = 1'b1;
    cyc = 0; hit = 1'b0;
    while (!hit && cyc < 50) begin
      @(posedge CPU_CLK);
      #1;
      cyc++;
      hit = mem_req && (word_idx == 3'd3);
    end
    chk("reached_word3", 32'(hit), 32'd1);
    #2;
    CPU_RST_N = 1'b0;
    #1;
    checkAllZero("async_reset");
    i_req = 1'b0;
    endPhase("reset_mid_burst");
    @(posedge CPU_CLK);
    #1;
    CPU_RST_N = 1'b1;
    pushBurst(1'b0, 1'b0, 32'h0000_3000, LW);
    i_req = 1'b1;
    runUntilDones(1, 50);
    endPhase("restart");

    pushBurst(1'b1, 1'b0, 32'hFFFF_FFE0, LW);
    d_addr = 32'hFFFF_FFF0; d_req = 1'b1;
    runUntilDones(1, 50);
    endPhase("top_of_space");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
